tx_frame_sequencer: RTL and testbench



---
 rtl/tx_seq_pkg.sv | 11 +
 rtl/crc_serial.sv | 25 ++
 rtl/tx_frame_sequencer.sv | 87 ++++++++
 tb/tb_tx_frame_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_seq_pkg.sv
// tx_seq_pkg: shared types and default constants for the TX frame sequencer
package tx_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_CRC, S_TAIL, S_END} state_t;
  localparam logic [1:0] CRC_NONE = 2'd0;
  localparam logic [1:0] CRC_5 = 2'd1;
  localparam logic [1:0] CRC_16 = 2'd2;
  localparam logic [15:0] CRC16_POLY_DEF = 16'h1021;
  localparam logic [15:0] CRC16_INIT_DEF = 16'hFFFF;
  localparam logic [4:0] CRC5_POLY_DEF = 5'h09;
  localparam logic [4:0] CRC5_INIT_DEF = 5'h09;
endpackage

// File: rtl/crc_serial.sv
// crc_serial: serial LFSR CRC with preset, data shift-in and MSB-first shift-out
module crc_serial #(
  parameter int W = 16,
  parameter logic [W-1:0] POLY = '0,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic shift_in,
  input  logic data,
  input  logic shift_out,
  input  logic complement,
  output logic crc_bit
);
  logic [W-1:0] r;
  logic fb;
  assign fb = data ^ r[W-1];
  assign crc_bit = r[W-1] ^ complement;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else if (init) r <= INIT;
    else if (shift_in) r <= {r[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    else if (shift_out) r <= {r[W-2:0], 1'b0};
endmodule

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: preamble -> data -> optional CRC -> tail frame sequencer
// driven by a bit-period strobe, with per-source advance strobes and abort.
module tx_frame_sequencer import tx_seq_pkg::*; #(
  parameter int TAIL_BITS = 1,
  parameter logic [15:0] CRC16_POLY = CRC16_POLY_DEF,
  parameter logic [15:0] CRC16_INIT = CRC16_INIT_DEF,
  parameter logic [4:0] CRC5_POLY = CRC5_POLY_DEF,
  parameter logic [4:0] CRC5_INIT = CRC5_INIT_DEF
) (
  input  logic       oscclk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       bit_tick,
  input  logic [1:0] crc_mode,
  input  logic       pre_bit,
  input  logic       pre_last,
  output logic       pre_adv,
  input  logic       data_bit,
  input  logic       data_last,
  output logic       data_adv,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       busy,
  output logic       done
);
  state_t state, state_nx;
  logic [1:0] mode;
  logic [4:0] cnt, tcnt, clen;
  logic ab, tail_tk, has_crc, crc_init, crc_shift, c16_bit, c5_bit, crc_bit;
  assign ab = abort && (state == S_PRE || state == S_DATA || state == S_CRC);
  // an aborting tick is itself the first tail bit
  assign tail_tk = bit_tick && (ab || state == S_TAIL);
  assign tcnt = ab ? 5'd0 : cnt;
  assign has_crc = mode == CRC_5 || mode == CRC_16;
  assign clen = mode == CRC_16 ? 5'd15 : 5'd4;
  assign crc_init = state == S_IDLE && start;
  assign crc_shift = bit_tick && state == S_CRC && !ab;
  assign crc_bit = mode == CRC_16 ? c16_bit : c5_bit;
  assign busy = state != S_IDLE;
  assign tx_valid = busy;
  always_comb begin
    state_nx = state;
    pre_adv = 1'b0;
    data_adv = 1'b0;
    if (state == S_IDLE) state_nx = start ? S_PRE : S_IDLE;
    else if (tail_tk) state_nx = tcnt == 5'(TAIL_BITS - 1) ? S_END : S_TAIL;
    else if (bit_tick)
      case (state)
        S_PRE: begin
          pre_adv = 1'b1;
          state_nx = pre_last ? S_DATA : S_PRE;
        end
        S_DATA: begin
          data_adv = 1'b1;
          state_nx = data_last ? (has_crc ? S_CRC : S_TAIL) : S_DATA;
        end
        S_CRC: state_nx = cnt == clen ? S_TAIL : S_CRC;
        S_END: state_nx = S_IDLE;
        default: state_nx = state;
      endcase
  end
  always_ff @(posedge oscclk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      mode <= CRC_NONE;
      cnt <= 5'd0;
      tx_bit <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= bit_tick && state == S_END;
      if (crc_init) mode <= crc_mode;
      cnt <= tail_tk ? tcnt + 5'd1 : state_nx != state ? 5'd0 : bit_tick ? cnt + 5'd1 : cnt;
      if (bit_tick && state != S_IDLE)
        tx_bit <= tail_tk ? 1'b1 : state == S_PRE ? pre_bit : state == S_DATA ? data_bit :
                  state == S_CRC ? crc_bit : 1'b0;
    end
  crc_serial #(.W(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
    .clk(oscclk), .rst_n(reset_n), .init(crc_init), .shift_in(data_adv), .data(data_bit),
    .shift_out(crc_shift), .complement(1'b1), .crc_bit(c16_bit)
  );
  crc_serial #(.W(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
    .clk(oscclk), .rst_n(reset_n), .init(crc_init), .shift_in(data_adv), .data(data_bit),
    .shift_out(crc_shift), .complement(1'b0), .crc_bit(c5_bit)
  );
endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: randomized frames on two sequencers (tail 1 and tail 3)
// checked tick by tick against a frame-level reference model.
module tb_tx_frame_sequencer;
  logic oscclk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, bit_tick = 1'b0;
  logic [1:0] crc_mode = 2'd0;
  logic pre_bit[2], pre_last[2], data_bit[2], data_last[2];
  logic pre_adv[2], data_adv[2], tx_bit[2], tx_valid[2], busy[2], done[2];
  int checks = 0, errors = 0;
  int pi[2], di[2], nb;
  logic pre_q[$], data_q[$], bb[$], obs[$];
  int bt[$];
  always #5 oscclk = ~oscclk;
  tx_frame_sequencer u1 (
    .oscclk(oscclk), .reset_n(reset_n), .start(start), .abort(abort), .bit_tick(bit_tick),
    .crc_mode(crc_mode), .pre_bit(pre_bit[0]), .pre_last(pre_last[0]), .pre_adv(pre_adv[0]),
    .data_bit(data_bit[0]), .data_last(data_last[0]), .data_adv(data_adv[0]),
    .tx_bit(tx_bit[0]), .tx_valid(tx_valid[0]), .busy(busy[0]), .done(done[0])
  );
  tx_frame_sequencer #(.TAIL_BITS(3)) u3 (
    .oscclk(oscclk), .reset_n(reset_n), .start(start), .abort(abort), .bit_tick(bit_tick),
    .crc_mode(crc_mode), .pre_bit(pre_bit[1]), .pre_last(pre_last[1]), .pre_adv(pre_adv[1]),
    .data_bit(data_bit[1]), .data_last(data_last[1]), .data_adv(data_adv[1]),
    .tx_bit(tx_bit[1]), .tx_valid(tx_valid[1]), .busy(busy[1]), .done(done[1])
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // expected on-air body: preamble, payload, CRC bits; truncated where abort hits
  task automatic build(input int mode, input int ab);
    logic [15:0] r, poly;
    logic fb;
    int w;
    bb.delete();
    bt.delete();
    foreach (pre_q[i]) begin bb.push_back(pre_q[i]); bt.push_back(0); end
    foreach (data_q[i]) begin bb.push_back(data_q[i]); bt.push_back(1); end
    if (mode == 1 || mode == 2) begin
      w = mode == 2 ? 16 : 5;
      r = mode == 2 ? 16'hFFFF : 16'h0009;
      poly = mode == 2 ? 16'h1021 : 16'h0009;
      foreach (data_q[i]) begin
        fb = data_q[i] ^ r[w-1];
        r = {r[14:0], 1'b0};
        if (w == 5) r[15:5] = '0;
        if (fb) r = r ^ poly;
      end
      if (mode == 2) r = ~r;
      for (int i = w - 1; i >= 0; i--) begin bb.push_back(r[i]); bt.push_back(2); end
    end
    if (ab >= 0) while (bb.size() > ab) begin void'(bb.pop_back()); void'(bt.pop_back()); end
  endtask
  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      pre_bit[k] = pi[k] < pre_q.size() ? pre_q[pi[k]] : 1'($urandom);
      pre_last[k] = pi[k] == pre_q.size() - 1;
      data_bit[k] = di[k] < data_q.size() ? data_q[di[k]] : 1'($urandom);
      data_last[k] = di[k] == data_q.size() - 1;
    end
  endtask
  task automatic idle_check(input string tag, input int t);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s busy%0d t%0d", tag, k, t), busy[k], t < nb + (k ? 3 : 1) + 1);
      chk($sformatf("%s valid%0d t%0d", tag, k, t), tx_valid[k], t < nb + (k ? 3 : 1) + 1);
      chk($sformatf("%s adv%0d t%0d", tag, k, t), {pre_adv[k], data_adv[k], done[k]}, 0);
    end
  endtask
  task automatic sample(input int t);
    int tl;
    logic eb;
    for (int k = 0; k < 2; k++) begin
      tl = k ? 3 : 1;
      eb = t < nb ? bb[t] : (t < nb + tl);
      if (k == 0) obs.push_back(tx_bit[0]);
      chk($sformatf("tx_bit%0d t%0d", k, t), tx_bit[k], eb);
      chk($sformatf("valid%0d t%0d", k, t), tx_valid[k], t < nb + tl);
      chk($sformatf("busy%0d t%0d", k, t), busy[k], t < nb + tl);
      chk($sformatf("done%0d t%0d", k, t), done[k], t == nb + tl);
      chk($sformatf("adv_idle%0d t%0d", k, t), {pre_adv[k], data_adv[k]}, 0);
    end
  endtask
  task automatic zero_check(input string tag);
    for (int k = 0; k < 2; k++)
      chk($sformatf("%s outs%0d", tag, k),
          {tx_bit[k], tx_valid[k], busy[k], done[k], pre_adv[k], data_adv[k]}, 0);
  endtask
  task automatic run_frame(input int mode, input int ab, input bit coinc, input bit mid,
                           input int rst_at);
    int epa, eda, npa[2], nda[2];
    logic pa[2], da[2];
    build(mode, ab);
    nb = bb.size();
    epa = 0;
    eda = 0;
    foreach (bt[i]) begin epa += int'(bt[i] == 0); eda += int'(bt[i] == 1); end
    for (int k = 0; k < 2; k++) begin pi[k] = 0; di[k] = 0; npa[k] = 0; nda[k] = 0; end
    obs.delete();
    start = 1'b1;
    bit_tick = coinc;
    crc_mode = 2'(mode);
    drive();
    @(negedge oscclk);
    for (int k = 0; k < 2; k++) chk($sformatf("start adv%0d", k), {pre_adv[k], data_adv[k]}, 0);
    @(posedge oscclk); #1;
    start = 1'b0;
    bit_tick = 1'b0;
    crc_mode = 2'($urandom);
    for (int t = 0; t < nb + 4; t++) begin
      repeat ($urandom_range(0, 2)) begin
        drive();
        @(negedge oscclk);
        idle_check("gap", t);
        @(posedge oscclk); #1;
      end
      if (ab >= 0 && t == ab) abort = 1'b1;
      bit_tick = 1'b1;
      drive();
      @(negedge oscclk);
      for (int k = 0; k < 2; k++) begin
        pa[k] = pre_adv[k];
        da[k] = data_adv[k];
        chk($sformatf("pre_adv%0d t%0d", k, t), pa[k], t < nb && bt[t] == 0);
        chk($sformatf("data_adv%0d t%0d", k, t), da[k], t < nb && bt[t] == 1);
        npa[k] += int'(pa[k]);
        nda[k] += int'(da[k]);
      end
      @(posedge oscclk); #1;
      bit_tick = 1'b0;
      for (int k = 0; k < 2; k++) begin pi[k] += int'(pa[k]); di[k] += int'(da[k]); end
      if (mid && t == 0) start = 1'b1;
      drive();
      @(negedge oscclk);
      sample(t);
      @(posedge oscclk); #1;
      start = 1'b0;
      if (t == rst_at) begin
        #2 reset_n = 1'b0;
        #1 zero_check("async_rst");
        @(posedge oscclk); #1;
        zero_check("held_rst");
        reset_n = 1'b1;
        abort = 1'b0;
        return;
      end
    end
    abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("npre_adv%0d", k), 16'(npa[k]), 16'(epa));
      chk($sformatf("ndata_adv%0d", k), 16'(nda[k]), 16'(eda));
    end
  endtask
  function automatic logic [15:0] obs_bits(input int from, input int n);
    logic [15:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[14:0], obs[from + i]};
    return v;
  endfunction
  task automatic load_std();
    logic [5:0] pv = 6'b101011;
    string s = "123456789";
    byte c;
    pre_q.delete();
    data_q.delete();
    for (int i = 5; i >= 0; i--) pre_q.push_back(pv[i]);
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      for (int b = 7; b >= 0; b--) data_q.push_back(c[b]);
    end
  endtask
  initial begin
    int p, d, m, cl, ab;
    for (int k = 0; k < 2; k++) begin pi[k] = 0; di[k] = 0; end
    nb = 0;
    drive();
    repeat (3) @(posedge oscclk);
    @(negedge oscclk);
    zero_check("reset");
    @(posedge oscclk); #1;
    reset_n = 1'b1;
    load_std();
    run_frame(2, -1, 1'b0, 1'b0, -1);
    chk("crc16_bits", obs_bits(78, 16), 16'hD64E);
    run_frame(1, -1, 1'b0, 1'b0, -1);
    chk("crc5_bits", obs_bits(78, 5), 16'h0000);
    run_frame(0, -1, 1'b1, 1'b1, -1);
    chk("no_crc_tail", obs[78], 1'b1);
    pre_q.delete();
    data_q.delete();
    pre_q.push_back(1'($urandom));
    data_q.push_back(1'($urandom));
    run_frame(0, -1, 1'b0, 1'b0, -1);
    load_std();
    run_frame(2, 16, 1'b0, 1'b0, -1);
    run_frame(2, -1, 1'b0, 1'b0, 6 + 72 + 3);
    run_frame(2, -1, 1'b0, 1'b0, -1);
    chk("crc16_after_rst", obs_bits(78, 16), 16'hD64E);
    for (int f = 0; f < 30; f++) begin
      p = $urandom_range(1, 8);
      d = $urandom_range(1, 40);
      m = $urandom_range(0, 3);
      cl = m == 1 ? 5 : m == 2 ? 16 : 0;
      ab = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, p + d + cl - 1)) : -1;
      pre_q.delete();
      data_q.delete();
      repeat (p) pre_q.push_back(1'($urandom));
      repeat (d) data_q.push_back(1'($urandom));
      run_frame(m, ab, 1'($urandom), 1'($urandom), -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
